// File: rtl/fifo_burst_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_sched_if
// Description : Bundle of FIFO drain, burst header, data beat and status
//               signals shared by the burst scheduler and its neighbours.
// Revision    : 1.0
// ============================================================================
interface fifo_burst_sched_if #(
    parameter int DATA_SIZE = 49
);
    logic [3:0]           enq;
    logic                 fifo_empty;
    logic [DATA_SIZE-1:0] fifo_do;
    logic                 fifo_deq;
    logic                 flush;
    logic                 hdr_valid;
    logic                 hdr_ready;
    logic [3:0]           hdr_len;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_last;
    logic                 stall;
    logic                 flush_done;
    logic                 ovf_err;

    // Scheduler side.
    modport slave (
        input  enq, fifo_empty, fifo_do, flush, hdr_ready, m_ready,
        output fifo_deq, hdr_valid, hdr_len, m_valid, m_data, m_last,
               stall, flush_done, ovf_err
    );

    // Environment side: FIFO, producers and downstream consumer.
    modport master (
        output enq, fifo_empty, fifo_do, flush, hdr_ready, m_ready,
        input  fifo_deq, hdr_valid, hdr_len, m_valid, m_data, m_last,
               stall, flush_done, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/fifo_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_sched
// Description : Drain-side burst scheduler for the 4-lane result FIFO:
//               occupancy mirror, length-headed bursts, flush and throttling.
// Revision    : 1.0
// ============================================================================
module fifo_burst_sched #(
    parameter int DATA_SIZE     = 49,
    parameter int FIFO_SIZE     = 8,
    parameter int FIFO_ADDR_LEN = 3,
    parameter int BURST_LEN     = 8,
    parameter int TIMEOUT       = 64
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fifo_burst_sched_if.slave    bus
);

    localparam int OCC_W = FIFO_ADDR_LEN + 3;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [OCC_W-1:0] c_CAP       = OCC_W'(4 * FIFO_SIZE);
    localparam logic [OCC_W-1:0] c_STALL_LVL = OCC_W'(4 * FIFO_SIZE - 4);
    localparam logic [OCC_W-1:0] c_BURST     = OCC_W'(BURST_LEN);
    localparam logic [3:0]       c_BURST4    = 4'(BURST_LEN);
    localparam logic [TMR_W-1:0] c_TMO_LAST  = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HDR  = 2'd1;
    localparam logic [1:0] c_SEND = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [OCC_W-1:0]     r_occ;
    logic [OCC_W-1:0]     w_occ_nxt;
    logic [OCC_W-1:0]     w_sum_in;
    logic [OCC_W-1:0]     w_sum;
    logic [2:0]           w_pop;
    logic                 w_ovf_evt;
    logic [TMR_W-1:0]     r_timer;
    logic [3:0]           r_len;
    logic [3:0]           w_len_new;
    logic [3:0]           r_beat;
    logic                 r_flush_pend;
    logic                 r_stall;
    logic                 r_ovf;
    logic                 w_trigger;
    logic                 w_tmr_run;
    logic                 w_last;

    logic                 w_hdr_valid;
    logic [3:0]           w_hdr_len;
    logic                 w_m_valid;
    logic [DATA_SIZE-1:0] w_m_data;
    logic                 w_m_last;
    logic                 w_deq;
    logic                 w_flush_done;

    // Occupancy mirror: enqueues and the pop of this cycle both count.
    always_comb begin
        w_pop     = 3'(bus.enq[0]) + 3'(bus.enq[1]) + 3'(bus.enq[2]) + 3'(bus.enq[3]);
        w_sum_in  = r_occ + OCC_W'(w_pop);
        w_sum     = w_sum_in - OCC_W'(w_deq);
        w_ovf_evt = (w_sum_in > c_CAP);
        w_occ_nxt = (w_sum > c_CAP) ? c_CAP : w_sum;
    end

    always_comb begin
        w_trigger = (r_occ >= c_BURST)
                  | (r_flush_pend & (r_occ != '0))
                  | (r_timer == c_TMO_LAST);
        w_tmr_run = (r_state == c_IDLE) & ~w_trigger & ~r_flush_pend
                  & (r_occ != '0) & (r_occ < c_BURST);
        w_len_new = (r_occ >= c_BURST) ? c_BURST4 : r_occ[3:0];
        w_last    = (r_beat == (r_len - 4'd1));
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_trigger)                    w_state_nxt = c_HDR;
            c_HDR:   if (bus.hdr_ready)                w_state_nxt = c_SEND;
            c_SEND:  if (w_m_valid & bus.m_ready & w_last) w_state_nxt = c_IDLE;
            default:                                   w_state_nxt = c_IDLE;
        endcase
    end

    // FSM: outputs; header and data phases are mutually exclusive by state
    always_comb begin
        w_hdr_valid  = 1'b0;
        w_hdr_len    = 4'd0;
        w_m_valid    = 1'b0;
        w_m_data     = '0;
        w_m_last     = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_flush_done = r_flush_pend & (r_occ == '0);
            end
            c_HDR: begin
                w_hdr_valid = 1'b1;
                w_hdr_len   = r_len;
            end
            c_SEND: begin
                w_m_valid = ~bus.fifo_empty;
                w_m_data  = bus.fifo_do;
                w_m_last  = w_last;
            end
            default: begin
                w_hdr_valid = 1'b0;
            end
        endcase
        w_deq = w_m_valid & bus.m_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ        <= '0;
            r_timer      <= '0;
            r_len        <= 4'd0;
            r_beat       <= 4'd0;
            r_flush_pend <= 1'b0;
            r_stall      <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_stall <= (w_occ_nxt >= c_STALL_LVL);
            r_ovf   <= r_ovf | w_ovf_evt;
            r_timer <= w_tmr_run ? (r_timer + 1'b1) : '0;

            // A flush arriving while one is pending merges into it.
            if (w_flush_done) begin
                r_flush_pend <= 1'b0;
            end else if (bus.flush) begin
                r_flush_pend <= 1'b1;
            end

            if ((r_state == c_IDLE) && w_trigger) begin
                r_len  <= w_len_new;
                r_beat <= 4'd0;
            end else if (w_deq) begin
                r_beat <= r_beat + 4'd1;
            end
        end
    end

    assign bus.hdr_valid  = w_hdr_valid;
    assign bus.hdr_len    = w_hdr_len;
    assign bus.m_valid    = w_m_valid;
    assign bus.m_data     = w_m_data;
    assign bus.m_last     = w_m_last;
    assign bus.fifo_deq   = w_deq;
    assign bus.stall      = r_stall;
    assign bus.flush_done = w_flush_done;
    assign bus.ovf_err    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_sched
// Description : Directed and randomised bench for fifo_burst_sched with a
//               queue-based FIFO and a word-level delivery scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_fifo_burst_sched;
    localparam int DW  = 49;
    localparam int CAP = 32;
    localparam int BL  = 8;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_burst_sched_if #(.DATA_SIZE(DW)) bus ();

    fifo_burst_sched #(
        .DATA_SIZE(DW), .FIFO_SIZE(8), .FIFO_ADDR_LEN(3), .BURST_LEN(BL), .TIMEOUT(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] lane_data [4];
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] sb [$];
    int seq = 1;

    // Behavioural lane FIFO, popped then pushed on each edge, shares rst.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
        end else begin
            if (bus.fifo_deq && fifo_q.size() > 0) void'(fifo_q.pop_front());
            for (int l = 0; l < 4; l++)
                if (bus.enq[l] && fifo_q.size() < CAP) fifo_q.push_back(lane_data[l]);
        end
        bus.fifo_empty <= (fifo_q.size() == 0);
        bus.fifo_do    <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    bit            mon_en = 1'b0;
    int            occ_m = 0, prev_occ = 0;
    bit            in_send = 1'b0;
    int            cur_len = 0, beat_m = 0;
    bit            prev_hv = 1'b0, prev_hr = 1'b0, prev_mv = 1'b0, prev_mr = 1'b0;
    logic [3:0]    prev_hl = 4'd0;
    logic [DW-1:0] prev_md = '0;
    int            bursts_done = 0, lasts = 0, delivered = 0, pushed = 0, fd_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle protocol and scoreboard checks, run on the falling edge.
    task automatic monitor();
        int pc, nxt, exp_len;
        bit acc;
        if (!mon_en) return;
        acc = bus.m_valid & bus.m_ready;
        chk("stall_vs_occ", 64'(bus.stall), 64'(occ_m >= CAP - 4));
        chk("deq_is_handshake", 64'(bus.fifo_deq), 64'(acc));
        if (bus.hdr_valid) chk("hdr_data_excl", 64'(bus.m_valid), 64'd0);
        if (in_send) chk("hdr_in_send", 64'(bus.hdr_valid), 64'd0);
        else         chk("data_outside_burst", 64'(bus.m_valid), 64'd0);
        if (bus.hdr_valid && !prev_hv) begin
            exp_len = (prev_occ > BL) ? BL : prev_occ;
            chk("hdr_len", 64'(bus.hdr_len), 64'(exp_len));
            cur_len = exp_len;
        end
        if (bus.hdr_valid && prev_hv && !prev_hr) chk("hdr_len_hold", 64'(bus.hdr_len), 64'(prev_hl));
        if (prev_mv && !prev_mr) begin
            chk("m_valid_hold", 64'(bus.m_valid), 64'd1);
            chk("m_data_hold", 64'(bus.m_data), 64'(prev_md));
        end
        if (bus.m_valid) begin
            chk("m_data", 64'(bus.m_data), (sb.size() > 0) ? 64'(sb[0]) : 64'hDEAD);
            chk("m_last", 64'(bus.m_last), 64'(beat_m == cur_len - 1));
        end

        prev_hv = bus.hdr_valid; prev_hr = bus.hdr_ready; prev_hl = bus.hdr_len;
        prev_mv = bus.m_valid;   prev_mr = bus.m_ready;   prev_md = bus.m_data;

        if (rst) begin
            occ_m = 0; prev_occ = 0; sb.delete(); in_send = 1'b0; beat_m = 0;
            prev_hv = 1'b0; prev_mv = 1'b0;
            return;
        end
        fd_cnt += int'(bus.flush_done);
        if (bus.hdr_valid && bus.hdr_ready) begin
            in_send = 1'b1;
            beat_m  = 0;
        end
        if (acc) begin
            if (sb.size() > 0) void'(sb.pop_front());
            delivered++;
            if (bus.m_last) lasts++;
            beat_m++;
            if (beat_m == cur_len) begin
                in_send = 1'b0;
                bursts_done++;
            end
        end
        pc = 0;
        for (int l = 0; l < 4; l++) begin
            if (bus.enq[l]) begin
                pc++;
                if (sb.size() < CAP) begin
                    sb.push_back(lane_data[l]);
                    pushed++;
                end
            end
        end
        nxt = occ_m + pc - int'(acc);
        prev_occ = occ_m;
        occ_m = (nxt > CAP) ? CAP : nxt;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic [3:0] m);
        for (int l = 0; l < 4; l++) begin
            lane_data[l] = {17'(seq), 32'($urandom)};
            seq++;
        end
        bus.enq = m;
    endtask

    task automatic wait_hdr(input int bound);
        for (int n = 0; n < bound && !bus.hdr_valid; n++) tick();
        chk("hdr_wait", 64'(bus.hdr_valid), 64'd1);
    endtask

    task automatic wait_burst_end(input int bound, output int cycles);
        int b0 = bursts_done;
        cycles = 0;
        while (bursts_done == b0 && cycles < bound) begin
            tick();
            cycles++;
        end
        chk("burst_end", 64'(bursts_done - b0), 64'd1);
    endtask

    task automatic push8_burst(input string tag);
        int l0, d0, cyc;
        for (int i = 0; i < 8; i++) begin
            drive_enq(4'b0001);
            tick();
        end
        drive_enq(4'b0000);
        chk({tag, "_hdr_not_yet"}, 64'(bus.hdr_valid), 64'd0);
        tick();
        chk({tag, "_hdr_valid"}, 64'(bus.hdr_valid), 64'd1);
        chk({tag, "_hdr_len"}, 64'(bus.hdr_len), 64'd8);
        l0 = lasts; d0 = delivered;
        wait_burst_end(40, cyc);
        chk({tag, "_cycles"}, 64'(cyc), 64'd9);
        chk({tag, "_lasts"}, 64'(lasts - l0), 64'd1);
        chk({tag, "_beats"}, 64'(delivered - d0), 64'd8);
    endtask

    initial begin
        int first, len_at, hv_cnt, d0, l0, f0, n, cyc;
        bus.enq = 4'b0000; bus.flush = 1'b0; bus.hdr_ready = 1'b0; bus.m_ready = 1'b0;
        for (int l = 0; l < 4; l++) lane_data[l] = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_hdr_valid", 64'(bus.hdr_valid), 64'd0);
        chk("rst_hdr_len", 64'(bus.hdr_len), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_ovf", 64'(bus.ovf_err), 64'd0);
        chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Full 8-word burst with ready held high.
        bus.hdr_ready = 1'b1; bus.m_ready = 1'b1;
        push8_burst("t1");
        hv_cnt = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            hv_cnt += int'(bus.hdr_valid);
        end
        chk("t1_quiet_after", 64'(hv_cnt), 64'd0);

        // Short burst forced by the idle timeout.
        drive_enq(4'b0111);
        tick();
        drive_enq(4'b0000);
        first = -1; len_at = 0; d0 = delivered; l0 = lasts;
        for (int k = 1; k <= 72; k++) begin
            tick();
            if (bus.hdr_valid && first < 0) begin
                first  = k;
                len_at = int'(bus.hdr_len);
            end
        end
        chk("t2_hdr_delay", 64'(first), 64'(TMO));
        chk("t2_hdr_len", 64'(len_at), 64'd3);
        chk("t2_beats", 64'(delivered - d0), 64'd3);
        chk("t2_lasts", 64'(lasts - l0), 64'd1);

        // Flush drains a partial burst without waiting for the timeout.
        drive_enq(4'b1111);
        tick();
        drive_enq(4'b0001);
        tick();
        drive_enq(4'b0000);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        f0 = fd_cnt;
        chk("t3_hdr_not_yet", 64'(bus.hdr_valid), 64'd0);
        tick();
        chk("t3_hdr_valid", 64'(bus.hdr_valid), 64'd1);
        chk("t3_hdr_len", 64'(bus.hdr_len), 64'd5);
        wait_burst_end(40, cyc);
        chk("t3_flush_done", 64'(bus.flush_done), 64'd1);
        tick();
        chk("t3_flush_done_pulse", 64'(bus.flush_done), 64'd0);
        chk("t3_flush_done_once", 64'(fd_cnt - f0), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t3_flush_empty", 64'(bus.flush_done), 64'd1);
        tick();
        chk("t3_flush_empty_pulse", 64'(bus.flush_done), 64'd0);

        // Fill to capacity with the header held off, then overflow.
        bus.hdr_ready = 1'b0;
        d0 = delivered;
        for (int k = 1; k <= 7; k++) begin
            drive_enq(4'b1111);
            tick();
            chk("t4_stall", 64'(bus.stall), 64'(4 * k >= CAP - 4));
        end
        drive_enq(4'b1111);
        tick();
        chk("t4_no_ovf_at_cap", 64'(bus.ovf_err), 64'd0);
        drive_enq(4'b1111);
        tick();
        drive_enq(4'b0000);
        chk("t4_ovf_set", 64'(bus.ovf_err), 64'd1);
        for (int k = 0; k < 3; k++) tick();
        chk("t4_ovf_sticky", 64'(bus.ovf_err), 64'd1);
        chk("t4_stall_full", 64'(bus.stall), 64'd1);
        bus.hdr_ready = 1'b1;
        for (n = 0; n < 200 && (delivered - d0) < CAP; n++) tick();
        chk("t4_drained_32", 64'(delivered - d0), 64'(CAP));
        hv_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            hv_cnt += int'(bus.hdr_valid);
        end
        chk("t4_occ_was_cap", 64'(hv_cnt), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_ovf_cleared", 64'(bus.ovf_err), 64'd0);

        // Random enqueues and backpressure.
        d0 = delivered; l0 = pushed;
        for (int c = 0; c < 600; c++) begin
            bus.hdr_ready = 1'($urandom_range(0, 1));
            bus.m_ready   = 1'($urandom_range(0, 1));
            if (!bus.stall && $urandom_range(0, 2) == 0) drive_enq(4'($urandom_range(0, 15)));
            else                                         drive_enq(4'b0000);
            tick();
        end
        drive_enq(4'b0000);
        bus.hdr_ready = 1'b1; bus.m_ready = 1'b1;
        for (n = 0; n < 400 && (sb.size() > 0 || in_send || bus.hdr_valid); n++) tick();
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        chk("t5_all_delivered", 64'(delivered - d0), 64'(pushed - l0));
        chk("t5_no_ovf", 64'(bus.ovf_err), 64'd0);

        // Reset in the middle of a burst, then a clean burst.
        for (int i = 0; i < 8; i++) begin
            drive_enq(4'b0001);
            tick();
        end
        drive_enq(4'b0000);
        wait_hdr(5);
        d0 = delivered;
        for (n = 0; n < 20 && (delivered - d0) < 2; n++) tick();
        chk("t6_mid_burst", 64'(bus.m_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_hdr_valid", 64'(bus.hdr_valid), 64'd0);
        chk("t6_hdr_len", 64'(bus.hdr_len), 64'd0);
        chk("t6_m_valid", 64'(bus.m_valid), 64'd0);
        chk("t6_m_last", 64'(bus.m_last), 64'd0);
        chk("t6_m_data", 64'(bus.m_data), 64'd0);
        chk("t6_deq", 64'(bus.fifo_deq), 64'd0);
        chk("t6_stall", 64'(bus.stall), 64'd0);
        push8_burst("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
